// File: rtl/display_scan_mux_if.sv
// Signal bundle between a segment-pattern source and the display scan multiplexer.
// The source side drives patterns and controls; the scan side drives the display pins.
interface display_scan_mux_if;
   logic [7:0] l1;
   logic [7:0] l2;
   logic [7:0] l3;
   logic       en;
   logic       blank_lz;
   logic       blink;
   logic [2:0] dp_mask;
   logic [7:0] seg;
   logic [2:0] an;
   logic       frame_start;

   modport master (
      output l1, l2, l3, en, blank_lz, blink, dp_mask,
      input  seg, an, frame_start
   );

   modport slave (
      input  l1, l2, l3, en, blank_lz, blink, dp_mask,
      output seg, an, frame_start
   );
endinterface

// File: rtl/display_scan_mux.sv
// Three-digit 7-segment scan driver: per-frame snapshot, blank gaps between digits,
// leading-zero suppression, DP overlay, blink and enable gating, registered outputs.
module display_scan_mux #(
   parameter int unsigned DIGIT_CYCLES   = 50000,
   parameter int unsigned BLANK_CYCLES   = 500,
   parameter int unsigned BLINK_FRAMES   = 64,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input logic                clk,
   input logic                reset,
   display_scan_mux_if.slave  io_disp
);

   localparam int unsigned CW      = $clog2(DIGIT_CYCLES);
   localparam int unsigned FW      = $clog2(BLINK_FRAMES);
   localparam logic [7:0]  ZERO    = 8'hFC;
   localparam logic [7:0]  SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [2:0]  AN_OFF  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;

   typedef enum logic [1:0] {
      SLOT_L1 = 2'd0,
      SLOT_L2 = 2'd1,
      SLOT_L3 = 2'd2
   } slot_e;

   logic [CW-1:0] r_cnt,  w_cnt_nxt;
   slot_e         r_idx,  w_idx_nxt;
   logic [FW-1:0] r_fcnt, w_fcnt_nxt;
   logic [7:0]    r_s1, r_s2, r_s3;
   logic [7:0]    w_s1_nxt, w_s2_nxt, w_s3_nxt;
   logic [7:0]    r_seg, w_seg_nxt;
   logic [2:0]    r_an,  w_an_nxt;
   logic          r_fs,  w_fs_nxt;

   logic          w_sup1, w_sup2, w_sup;
   logic          w_dark;
   logic [7:0]    w_pat;
   logic [2:0]    w_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt  <= '0;
         r_idx  <= SLOT_L1;
         r_fcnt <= '0;
         r_s1   <= '0;
         r_s2   <= '0;
         r_s3   <= '0;
         r_seg  <= SEG_OFF;
         r_an   <= AN_OFF;
         r_fs   <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_idx  <= w_idx_nxt;
         r_fcnt <= w_fcnt_nxt;
         r_s1   <= w_s1_nxt;
         r_s2   <= w_s2_nxt;
         r_s3   <= w_s3_nxt;
         r_seg  <= w_seg_nxt;
         r_an   <= w_an_nxt;
         r_fs   <= w_fs_nxt;
      end
   end

   always_comb begin
      w_cnt_nxt  = r_cnt + CW'(1);
      w_idx_nxt  = r_idx;
      w_fcnt_nxt = r_fcnt;
      w_s1_nxt   = r_s1;
      w_s2_nxt   = r_s2;
      w_s3_nxt   = r_s3;
      w_fs_nxt   = 1'b0;

      if (r_cnt == CW'(DIGIT_CYCLES - 1)) begin
         w_cnt_nxt = '0;
         case (r_idx)
            SLOT_L1: w_idx_nxt = SLOT_L2;
            SLOT_L2: w_idx_nxt = SLOT_L3;
            default: w_idx_nxt = SLOT_L1;
         endcase
      end

      if ((r_cnt == '0) && (r_idx == SLOT_L1)) begin
         w_s1_nxt   = io_disp.l1;
         w_s2_nxt   = io_disp.l2;
         w_s3_nxt   = io_disp.l3;
         w_fcnt_nxt = r_fcnt + FW'(1);
         w_fs_nxt   = 1'b1;
      end
   end

   // cnt=0 is always inside the blank gap, so the snapshot loaded on the frame
   // edge is already in r_s* before any digit of that frame is lit.
   always_comb begin
      w_sup1 = io_disp.blank_lz && (r_s1 == ZERO);
      w_sup2 = w_sup1 && (r_s2 == ZERO);
      w_pat  = '0;
      w_sel  = '0;
      w_sup  = 1'b0;

      case (r_idx)
         SLOT_L1: begin
            w_pat = r_s1 | {7'b0, io_disp.dp_mask[2]};
            w_sel = 3'b100;
            w_sup = w_sup1;
         end
         SLOT_L2: begin
            w_pat = r_s2 | {7'b0, io_disp.dp_mask[1]};
            w_sel = 3'b010;
            w_sup = w_sup2;
         end
         SLOT_L3: begin
            w_pat = r_s3 | {7'b0, io_disp.dp_mask[0]};
            w_sel = 3'b001;
         end
         default: begin
            w_pat = '0;
            w_sel = '0;
         end
      endcase

      // Upper half of the power-of-two frame count is the blink-off half.
      w_dark = !io_disp.en
             || (io_disp.blink && r_fcnt[FW-1])
             || (r_cnt < CW'(BLANK_CYCLES))
             || w_sup;

      if (w_dark) begin
         w_seg_nxt = SEG_OFF;
         w_an_nxt  = AN_OFF;
      end else begin
         w_seg_nxt = SEG_ACTIVE_LOW ? ~w_pat : w_pat;
         w_an_nxt  = AN_ACTIVE_LOW ? ~w_sel : w_sel;
      end
   end

   assign io_disp.seg         = r_seg;
   assign io_disp.an          = r_an;
   assign io_disp.frame_start = r_fs;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux: a position-in-frame reference model pushes
// the expected outputs for every clock edge; a negedge monitor pops and compares.
module tb_display_scan_mux;

   localparam int unsigned D  = 8;
   localparam int unsigned B  = 2;
   localparam int unsigned BF = 4;
   localparam logic [7:0]  Z  = 8'hFC;

   typedef struct packed {
      logic [7:0] seg;
      logic [2:0] an;
      logic       fs;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   display_scan_mux_if bus();

   display_scan_mux #(
      .DIGIT_CYCLES  (D),
      .BLANK_CYCLES  (B),
      .BLINK_FRAMES  (BF),
      .SEG_ACTIVE_LOW(1'b1),
      .AN_ACTIVE_LOW (1'b1)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_disp(bus.slave)
   );

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   started  = 1'b0;

   // Reference model: output after an edge depends only on how many non-reset
   // edges preceded it (pos), the inputs at that edge and the frame snapshot.
   initial begin
      int unsigned pos;
      int unsigned slot;
      int unsigned w;
      int unsigned fc;
      logic [7:0]  snap [3];
      logic [7:0]  pat;
      logic [2:0]  sel;
      bit          sup;
      bit          lit;
      exp_t        e;
      pos = 0;
      fc  = 0;
      for (int i = 0; i < 3; i++) snap[i] = 8'h00;
      forever begin
         @(posedge clk);
         if (reset) begin
            e   = '{seg: 8'hFF, an: 3'b111, fs: 1'b0};
            pos = 0;
         end else begin
            slot = (pos / D) % 3;
            w    = pos % D;
            if (pos % (3 * D) == 0) begin
               snap[0] = bus.l1;
               snap[1] = bus.l2;
               snap[2] = bus.l3;
               fc      = (pos / (3 * D) + 1) % BF;
            end
            if (slot == 0)      sup = bus.blank_lz && (snap[0] == Z);
            else if (slot == 1) sup = bus.blank_lz && (snap[0] == Z) && (snap[1] == Z);
            else                sup = 1'b0;
            lit = bus.en && !(bus.blink && (fc >= BF / 2)) && (w >= B) && !sup;
            pat = snap[slot] | {7'b0, bus.dp_mask[2 - slot]};
            sel = 3'b100 >> slot;
            e.seg = lit ? ~pat : 8'hFF;
            e.an  = lit ? ~sel : 3'b111;
            e.fs  = (pos % (3 * D) == 0);
            pos++;
         end
         q.push_back(e);
         started = 1'b1;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (started) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
            end else begin
               e = q.pop_front();
               if (bus.seg !== e.seg) begin
                  n_fail++;
                  $display("FAIL seg @%0t: got %h expected %h", $time, bus.seg, e.seg);
               end
               n_checks++;
               if (bus.an !== e.an) begin
                  n_fail++;
                  $display("FAIL an @%0t: got %b expected %b", $time, bus.an, e.an);
               end
               n_checks++;
               if (bus.frame_start !== e.fs) begin
                  n_fail++;
                  $display("FAIL frame_start @%0t: got %b expected %b", $time, bus.frame_start, e.fs);
               end
            end
         end
      end
   end

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 4))
         0:       return 8'hFC;
         1:       return 8'h60;
         2:       return 8'hDA;
         3:       return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_pats(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      bus.l1 = a;
      bus.l2 = b;
      bus.l3 = c;
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_pats(pick(), pick(), pick());
         bus.en       = 1'($urandom);
         bus.blank_lz = 1'($urandom);
         bus.blink    = 1'($urandom);
         bus.dp_mask  = 3'($urandom);
         cyc(1);
      end

      reset = 1'b0;
      set_pats(8'h60, 8'hDA, 8'hF2);
      bus.en = 1'b1; bus.blank_lz = 1'b0; bus.blink = 1'b0; bus.dp_mask = 3'b000;
      cyc(48);

      set_pats(Z, Z, Z);
      bus.blank_lz = 1'b1;
      cyc(48);
      bus.l2 = 8'h60;
      cyc(48);

      set_pats(8'h60, 8'hDA, 8'hF2);
      bus.blank_lz = 1'b0;
      cyc(27);
      bus.l2 = 8'h60;
      cyc(45);

      bus.l2 = 8'hDA;
      bus.dp_mask = 3'b010;
      cyc(48);
      bus.dp_mask = 3'b000;

      bus.blink = 1'b1;
      cyc(24 * 8);
      bus.blink = 1'b0;

      cyc(5);
      bus.en = 1'b0;
      cyc(50);
      bus.en = 1'b1;
      cyc(10);

      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(12);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(30);

      for (int i = 0; i < 800; i++) begin
         case ($urandom_range(0, 15))
            0: bus.l1 = pick();
            1: bus.l2 = pick();
            2: bus.l3 = pick();
            3: bus.en = ($urandom_range(0, 3) != 0);
            4: bus.blank_lz = 1'($urandom);
            5: bus.blink = 1'($urandom);
            6: bus.dp_mask = 3'($urandom);
            default: ;
         endcase
         reset = ($urandom_range(0, 199) == 0);
         cyc(1);
      end
      reset = 1'b0;
      cyc(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scan_mux.md
# display_scan_mux

Time-multiplexed driver for a three-digit common-anode/common-cathode 7-segment display, placed directly downstream of the binary-to-7-segment converter. It takes the three 8-bit segment patterns (hundreds, tens, ones) and scans them onto one shared segment bus with per-digit enables. It adds anti-ghosting blank gaps, leading-zero suppression, decimal-point overlay, blinking and per-frame snapshotting so a digit never tears mid-frame.

## Interface
- DIGIT_CYCLES, 50000: clock cycles per digit slot; valid range 2..2^20.
- BLANK_CYCLES, 500: cycles at the start of each slot with all digits off; must satisfy 1 ≤ BLANK_CYCLES < DIGIT_CYCLES.
- BLINK_FRAMES, 64: blink period in frames; must be a power of 2 and ≥ 2.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment drives 0 on `seg`.
- AN_ACTIVE_LOW, 1: 1 means an enabled digit drives 0 on `an`.
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- l1  in  8  hundreds pattern {A,B,C,D,E,F,G,DP}, 1 = lit.
- l2  in  8  tens pattern, same format.
- l3  in  8  ones pattern, same format.
- en  in  1  display enable; 0 forces all digits off.
- blank_lz  in  1  leading-zero suppression enable.
- blink  in  1  blink enable.
- dp_mask  in  3  DP force-on: bit2→l1, bit1→l2, bit0→l3.
- seg  out  8  shared segment bus {A..G,DP}, polarity per SEG_ACTIVE_LOW.
- an  out  3  digit enables: an[2]=l1, an[1]=l2, an[0]=l3, polarity per AN_ACTIVE_LOW.
- frame_start  out  1  one-cycle pulse at the start of each frame.

## Operation
- State consists of:
  - `cnt`: 0..DIGIT_CYCLES-1.
  - `idx`: 0..2, scan order l1, l2, l3.
  - `fcnt`: 0..BLINK_FRAMES-1.
  - Snapshot registers s1, s2, s3.
- Each clock, `cnt` increments. At DIGIT_CYCLES-1, `cnt` wraps to 0 and `idx` advances; `idx` 2 wraps to 0.
- Frame boundary: the cycle with cnt=0 and idx=0. On that edge:
  - s1..s3 load from l1..l3.
  - `fcnt` increments modulo BLINK_FRAMES.
  - `frame_start` pulses.
- Input changes mid-frame never affect the current frame.
- Per-slot phases:
  - BLANK, while cnt < BLANK_CYCLES: all `an` inactive and `seg` all-unlit.
  - ON, otherwise: `an` for the current `idx` is active and `seg` shows the processed pattern.
- Leading-zero suppression (blank_lz=1), where Z = 8'hFC ("0" without DP):
  - s1 is suppressed if s1 == Z.
  - s2 is suppressed if s1 is suppressed and s2 == Z.
  - s3 is never suppressed.
  - A suppressed digit keeps its `an` inactive for the whole slot. Slot timing is unchanged.
- DP overlay: the pattern's bit0 is ORed with the matching `dp_mask` bit. The overlay applies before the suppression check does not; suppression compares the raw snapshot. A suppressed digit stays dark even when its `dp_mask` bit is set.
- Display gating: digits are dark, with counters still running, when either holds:
  - en=0, or
  - blink=1 and fcnt ≥ BLINK_FRAMES/2.
- Pattern 8'h00 displays as an enabled but unlit digit; it is not treated as suppressed.

## Timing
- `seg`, `an` and `frame_start` are registered. They reflect the counter state of the preceding cycle, giving 1-cycle latency.
- Reset values:
  - seg = all-unlit (8'hFF when active-low, else 8'h00).
  - an = all-inactive (3'b111 when active-low, else 3'b000).
  - frame_start = 0.
  - cnt = idx = fcnt = 0; s1..s3 = 0.
- After reset release, at the first edge:
  - cnt=0, idx=0 is a frame boundary and the snapshot loads.
  - `frame_start` = 1 during the following cycle.
- The first digit (l1) enable goes active BLANK_CYCLES+1 cycles after reset release.
- `frame_start` period is exactly 3·DIGIT_CYCLES cycles.
- Each digit is on for DIGIT_CYCLES−BLANK_CYCLES cycles per frame.
- There is never a cycle with two `an` bits active.
- `en` falling: `an` goes inactive on the next edge.
- `en` rising: the display resumes mid-scan at the current slot, from the current ON/BLANK phase; there is no restart.
- Reset asserted mid-slot: outputs take reset values at the next edge and the scan restarts at l1 with a full BLANK phase.
- If `blink` and the frame boundary coincide, the new `fcnt` value governs that frame.

## Test plan
All scenarios use DIGIT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=4, and both polarities active-low.
- Hold reset 3 cycles with random inputs → seg=8'hFF, an=3'b111, frame_start=0 throughout.
- Basic scan: l1=8'h60, l2=8'hDA, l3=8'hF2, en=1, blank_lz=0 → repeating 24-cycle pattern:
  - an=111 for 2 cycles, then an=011 with seg=8'h9F for 6 cycles.
  - an=111 for 2 cycles, then an=101 with seg=8'h25 for 6 cycles.
  - an=111 for 2 cycles, then an=110 with seg=8'h0D for 6 cycles.
  - frame_start pulses every 24 cycles.
- Leading zeros, blank_lz=1:
  - l1=l2=l3=8'hFC → an[2] and an[1] never low; an[0] low with seg=8'h03.
  - Then l2=8'h60 → only an[2] is suppressed; an[1] shows seg=8'h9F.
- Snapshot and DP:
  - Change l2 from 8'hDA to 8'h60 during the l1 slot → the current frame still shows 8'h25 on an=101; the next frame shows 8'h9F.
  - dp_mask=3'b010 → the tens digit shows seg=8'h24.
- Blink and enable:
  - blink=1 → 2 frames of normal scan, then 2 frames with an=111 constantly, repeating.
  - en=0 mid-ON-phase → an=111 on the next cycle; frame_start still pulses every 24 cycles.
- Reset mid-scan: assert reset for 1 cycle during the l2 ON phase → next cycle seg=8'hFF, an=111; after release, an=011 first appears 3 cycles later.
